// File: rtl/sub_shift_rows.sv
// Iterative SubBytes+ShiftRows (OP=1) or InvShiftRows+InvSubBytes (OP=0) over one shared 32-bit S-box lane.
// Optional HEA_SBOX_PIPE_EN registers the lane output, adding one drain cycle per block.
module sub_shift_rows #(
    parameter int OP = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] s_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] s_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t        state_r, state_s;
    logic [127:0]  in_r, sub_r;
    logic [1:0]    col_r;
    logic          valid_r;
    logic          accept_s, lookup_s, last_s, wr_en_s;
    logic [1:0]    wr_col_s;
    logic [31:0]   lane_in_s, lane_out_s, wr_data_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    // Column select for the shared S-box lane
    always_comb begin
        case (col_r)
            2'd0:    lane_in_s = in_r[127:96];
            2'd1:    lane_in_s = in_r[95:64];
            2'd2:    lane_in_s = in_r[63:32];
            2'd3:    lane_in_s = in_r[31:0];
            default: lane_in_s = 32'd0;
        endcase
    end

    // Four byte substitutions in parallel
    always_comb begin
        lane_out_s = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (OP != 0) begin
                lane_out_s[8*i +: 8] = sbox_fwd(lane_in_s[8*i +: 8]);
            end else begin
                lane_out_s[8*i +: 8] = sbox_inv(lane_in_s[8*i +: 8]);
            end
        end
    end

`ifdef HEA_SBOX_PIPE_EN
    logic [31:0] pipe_r;
    logic [1:0]  pipe_col_r;
    logic        pipe_vld_r, drain_r;

    assign lookup_s  = (state_r == BUSY) && !drain_r;
    assign last_s    = drain_r;
    assign wr_en_s   = pipe_vld_r;
    assign wr_col_s  = pipe_col_r;
    assign wr_data_s = pipe_r;

    // Lane output register; drain_r marks the cycle that retires column 3
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_r     <= 32'd0;
            pipe_col_r <= 2'd0;
            pipe_vld_r <= 1'b0;
            drain_r    <= 1'b0;
        end else begin
            pipe_vld_r <= lookup_s;
            if (lookup_s) begin
                pipe_r     <= lane_out_s;
                pipe_col_r <= col_r;
            end else begin
                pipe_r     <= pipe_r;
                pipe_col_r <= pipe_col_r;
            end
            if (accept_s) begin
                drain_r <= 1'b0;
            end else if (lookup_s && col_r == 2'd3) begin
                drain_r <= 1'b1;
            end else begin
                drain_r <= drain_r;
            end
        end
    end
`else
    assign lookup_s  = (state_r == BUSY);
    assign last_s    = (col_r == 2'd3);
    assign wr_en_s   = lookup_s;
    assign wr_col_s  = col_r;
    assign wr_data_s = lane_out_s;
`endif

    // State register plus registered valid flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            valid_r <= (state_s == DONE);
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? BUSY : IDLE;
            BUSY:    state_s = last_s ? DONE : BUSY;
            DONE: begin
                if (ready_i) begin
                    state_s = accept_s ? BUSY : IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs; ready_o intentionally follows ready_i while DONE
    always_comb begin
        ready_o  = (state_r == IDLE) || ((state_r == DONE) && ready_i);
        accept_s = valid_i && ready_o;
    end

    assign valid_o = valid_r;

    // Input capture, column counter and substituted-state buffer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_r  <= 128'd0;
            col_r <= 2'd0;
            sub_r <= 128'd0;
        end else begin
            if (accept_s) begin
                in_r  <= s_i;
                col_r <= 2'd0;
            end else if (lookup_s) begin
                col_r <= col_r + 2'd1;
            end else begin
                col_r <= col_r;
            end
            for (int c = 0; c < 4; c++) begin
                if (wr_en_s && wr_col_s == 2'(c)) begin
                    sub_r[32*(3-c) +: 32] <= wr_data_s;
                end
            end
        end
    end

    // Row rotation is pure wiring from the substituted buffer
    always_comb begin
        s_o = 128'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (OP != 0) begin
                    s_o[8*(15-(4*c+r)) +: 8] = sub_r[8*(15-(4*((c+r)%4)+r)) +: 8];
                end else begin
                    s_o[8*(15-(4*c+r)) +: 8] = sub_r[8*(15-(4*((c-r+4)%4)+r)) +: 8];
                end
            end
        end
    end

endmodule

// File: doc/sub_shift_rows.md
# sub_shift_rows

Iterative SubBytes + ShiftRows stage (or InvShiftRows + InvSubBytes when decrypting) for the HEA AES datapath. It sits directly upstream of `mix_columns` and feeds it a 128-bit state. It shares one 32-bit lane of four S-boxes across the four state columns, so each block takes four lookup cycles. Valid/ready handshakes on both sides decouple it from the round controller and the downstream stage.

## Interface
- `OP`, default 1: 1 = encrypt (`sbox`, ShiftRows); 0 = decrypt (`inv_sbox`, InvShiftRows). Both functions come from `hea_func_pack`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `valid_i`  in  1  input state valid.
- `ready_o`  out  1  block can accept a state.
- `s_i`  in  128  input state.
- `valid_o`  out  1  output state valid.
- `ready_i`  in  1  downstream (`mix_columns` consumer) ready.
- `s_o`  out  128  substituted and shifted state.

## Operation
- Byte mapping: byte i = `s[8*(15-i) +: 8]`; byte 4c+r is row r, column c.
- Registers:
  - input buffer `in_q[127:0]`
  - substituted buffer `sub_q[127:0]`
  - 2-bit column counter `col_q`
  - FSM state
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `ready_o`=1. On `valid_i`: `in_q`<=`s_i`, `col_q`<=0, go to BUSY.
  - BUSY: each cycle, `sub_q` column `col_q` <= S-box of `in_q` column `col_q` (4 bytes in parallel); `col_q`++. After the column-3 write, go to DONE.
  - DONE: `valid_o`=1. On `ready_i`: if `valid_i`, capture the new state and go to BUSY with `col_q`=0; otherwise go to IDLE.
- `ready_o` = (state==IDLE) || (state==DONE && `ready_i`). This is a combinational path from `ready_i` and is permitted.
- Shift is pure wiring on the `s_o` path, where out[r][c] is taken from `sub_q`:
  - Encrypt: out[r][c] = `sub_q`[r][(c+r) mod 4].
  - Decrypt: out[r][c] = `sub_q`[r][(c−r) mod 4].
  - Column indices wrap mod 4.
- `s_o` is defined only while `valid_o`=1. It is stable while `valid_o`=1 and `ready_i`=0.
- `valid_i` is ignored in BUSY, and in DONE unless `ready_i`=1.
- Reset values:
  - State: IDLE.
  - Registers: `col_q`=0, `in_q`=0, `sub_q`=0.
  - Outputs: `valid_o`=0, `s_o`=0, `ready_o`=1 (combinational from IDLE).
- Reset mid-operation abandons the block; no partial output is ever flagged valid.

## Timing
- Accept edge E0 (`valid_i` && `ready_o`). Lookups at E1..E4. `valid_o` rises after E4: latency 4 cycles.
- Output handshake at the earliest at E5. A simultaneous accept at E5 gives a throughput of one block per 5 cycles.
- `valid_o` stays high until the edge with `ready_i`=1, then deasserts on the next cycle unless a new block completes.
- All outputs except `ready_o` are registered.

## Configuration
- `HEA_SBOX_PIPE_EN` defined:
  - A 32-bit register is inserted after the S-box lane.
  - The column k lookup result is written into `sub_q` one cycle later.
  - BUSY lasts 5 cycles (4 lookups + 1 drain), giving latency 5 and a 6-cycle back-to-back period.
  - Handshake rules are unchanged.
- `HEA_SBOX_PIPE_EN` undefined: S-box output writes `sub_q` directly; latency 4.

## Test plan
- Encrypt, FIPS-197 App. B round 1: `s_i`=193de3bea0f4e22b9ac68d2ae9f84808 -> `s_o`=d4bf5d30e0b452aeb84111f11e2798e5, `valid_o` exactly 4 cycles after accept (5 with `HEA_SBOX_PIPE_EN`).
- Decrypt (`OP`=0): `s_i`=d4bf5d30e0b452aeb84111f11e2798e5 -> `s_o`=193de3bea0f4e22b9ac68d2ae9f84808.
- All-zero input: encrypt -> all bytes 63; decrypt -> all bytes 52.
- Backpressure: hold `ready_i`=0 for 10 cycles in DONE -> `s_o` and `valid_o` stable and `ready_o`=0. Then `ready_i`=1 with `valid_i`=1 -> output consumed and next block accepted on the same edge.
- `valid_i`=1 held during BUSY -> not accepted (`ready_o`=0), first result unaffected.
- Assert `rst_ni` at lookup cycle 2 -> `valid_o`=0 and `s_o`=0 immediately, `ready_o`=1. The next accepted block produces the correct result with nominal latency.
